// File: rtl/whack_light_sequencer.sv
// Whack-a-mole light sequencer: LFSR-picked single light per flick, gap/on timing, hit/miss/flick tallies.
// Optional WHACK_SPEEDUP_EN: on-time shrinks by 1/8 per successful hit (floored at 16 cycles).
module whack_light_sequencer #(
   parameter int N_LIGHTS = 9,
   parameter int CNT_W    = 28,
   parameter int FLICK_W  = 6,
   localparam int POS_W   = $clog2(N_LIGHTS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                load_seed,
   input  logic [15:0]         seed,
   input  logic [CNT_W-1:0]    time_on,
   input  logic [CNT_W-1:0]    time_between,
   input  logic [FLICK_W-1:0]  round_len,
   input  logic [N_LIGHTS-1:0] hits,
   output logic [N_LIGHTS-1:0] lights,
   output logic [POS_W-1:0]    light_pos,
   output logic                light_valid,
   output logic [FLICK_W-1:0]  flick_count,
   output logic [FLICK_W-1:0]  hit_count,
   output logic [FLICK_W-1:0]  miss_count,
   output logic                done
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_BTWN = 3'd1;
   localparam logic [2:0] PICK      = 3'd2;
   localparam logic [2:0] WAIT_ON   = 3'd3;
   localparam logic [2:0] END_CHECK = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [POS_W-1:0]   light_pos_q, light_pos_d;
   logic               light_valid_q, light_valid_d;
   logic [FLICK_W-1:0] flick_count_q, flick_count_d;
   logic [FLICK_W-1:0] hit_count_q, hit_count_d;
   logic [FLICK_W-1:0] miss_count_q, miss_count_d;
`ifdef WHACK_SPEEDUP_EN
   logic [CNT_W-1:0]   on_time_q, on_time_d;
   logic [CNT_W-1:0]   on_time_shrunk;
`endif

   logic [N_LIGHTS-1:0] pos_mask;
   logic [POS_W-1:0]    cand;
   logic [POS_W-1:0]    pick_pos;
   logic                hit_ok;
   logic                wrong_press;
   logic                timeout;
   logic                clr_counts;
   logic                flick_inc;
   logic                hit_inc;

   function automatic logic [FLICK_W-1:0] sat_add(input logic [FLICK_W-1:0] v, input logic [1:0] n);
      logic [FLICK_W:0] s;
      s = {1'b0, v} + (FLICK_W+1)'(n);
      return s[FLICK_W] ? '1 : s[FLICK_W-1:0];
   endfunction

   always_comb begin
      pos_mask = '0;
      pos_mask[light_pos_q] = 1'b1;
      cand = POS_W'(lfsr_q % N_LIGHTS);
      pick_pos = cand;
      if (cand == light_pos_q && flick_count_q != '0)
         pick_pos = (cand == POS_W'(N_LIGHTS-1)) ? '0 : cand + 1'b1;
   end

   always_comb begin
      lfsr_d = load_seed ? ((seed == '0) ? 16'h0001 : seed)
                         : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      state_d       = state_q;
      cnt_d         = cnt_q;
      light_pos_d   = light_pos_q;
      light_valid_d = light_valid_q;
      clr_counts    = 1'b0;
      flick_inc     = 1'b0;
      hit_inc       = 1'b0;
      timeout       = 1'b0;
      hit_ok        = (state_q == WAIT_ON) && hits[light_pos_q];
      // Only the lit position is exempt, and only while it is actually lit.
      wrong_press   = (state_q == WAIT_BTWN || state_q == PICK || state_q == WAIT_ON || state_q == END_CHECK)
                      && |(hits & ~((state_q == WAIT_ON) ? pos_mask : '0));
`ifdef WHACK_SPEEDUP_EN
      on_time_d      = on_time_q;
      on_time_shrunk = on_time_q - (on_time_q >> 3);
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WAIT_BTWN;
               cnt_d      = time_between;
               clr_counts = 1'b1;
`ifdef WHACK_SPEEDUP_EN
               on_time_d  = time_on;
`endif
            end
         end
         WAIT_BTWN: begin
            if (start) begin
               if (cnt_q == '0) state_d = PICK;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         PICK: begin
            light_pos_d   = pick_pos;
            light_valid_d = 1'b1;
            flick_inc     = 1'b1;
`ifdef WHACK_SPEEDUP_EN
            cnt_d         = on_time_q;
`else
            cnt_d         = time_on;
`endif
            state_d       = WAIT_ON;
         end
         WAIT_ON: begin
            // A hit wins over a same-cycle timeout.
            if (hit_ok) begin
               hit_inc       = 1'b1;
               light_valid_d = 1'b0;
               state_d       = END_CHECK;
`ifdef WHACK_SPEEDUP_EN
               if (on_time_shrunk < CNT_W'(16))
                  on_time_d = (on_time_q < CNT_W'(16)) ? on_time_q : CNT_W'(16);
               else
                  on_time_d = on_time_shrunk;
`endif
            end else if (start) begin
               if (cnt_q == '0) begin
                  timeout       = 1'b1;
                  light_valid_d = 1'b0;
                  state_d       = END_CHECK;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         END_CHECK: begin
            if (round_len != '0 && flick_count_q >= round_len) begin
               state_d = DONE;
            end else begin
               cnt_d   = time_between;
               state_d = WAIT_BTWN;
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (clr_counts) begin
         flick_count_d = '0;
         hit_count_d   = '0;
         miss_count_d  = '0;
      end else begin
         flick_count_d = sat_add(flick_count_q, {1'b0, flick_inc});
         hit_count_d   = sat_add(hit_count_q, {1'b0, hit_inc});
         miss_count_d  = sat_add(miss_count_q, {1'b0, wrong_press} + {1'b0, timeout});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         lfsr_q        <= 16'hACE1;
         light_pos_q   <= '0;
         light_valid_q <= 1'b0;
         flick_count_q <= '0;
         hit_count_q   <= '0;
         miss_count_q  <= '0;
`ifdef WHACK_SPEEDUP_EN
         on_time_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lfsr_q        <= lfsr_d;
         light_pos_q   <= light_pos_d;
         light_valid_q <= light_valid_d;
         flick_count_q <= flick_count_d;
         hit_count_q   <= hit_count_d;
         miss_count_q  <= miss_count_d;
`ifdef WHACK_SPEEDUP_EN
         on_time_q     <= on_time_d;
`endif
      end
   end

   assign lights      = light_valid_q ? pos_mask : '0;
   assign light_pos   = light_pos_q;
   assign light_valid = light_valid_q;
   assign flick_count = flick_count_q;
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_whack_light_sequencer.sv
// Directed self-checking bench for whack_light_sequencer (default parameters, speedup disabled).
module tb_whack_light_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        load_seed = 1'b0;
   logic [15:0] seed = '0;
   logic [27:0] time_on = '0;
   logic [27:0] time_between = '0;
   logic [5:0]  round_len = '0;
   logic [8:0]  hits = '0;
   logic [8:0]  lights;
   logic [3:0]  light_pos;
   logic        light_valid;
   logic [5:0]  flick_count;
   logic [5:0]  hit_count;
   logic [5:0]  miss_count;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [15:0] m_pick = 16'hACE1;

   whack_light_sequencer #(.N_LIGHTS(9), .CNT_W(28), .FLICK_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .load_seed(load_seed), .seed(seed),
      .time_on(time_on), .time_between(time_between), .round_len(round_len), .hits(hits),
      .lights(lights), .light_pos(light_pos), .light_valid(light_valid),
      .flick_count(flick_count), .hit_count(hit_count), .miss_count(miss_count), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [3:0] exp_pick(input logic [15:0] l, input logic [3:0] prev, input bit first);
      int c;
      c = int'(l) % 9;
      if (!first && c == int'(prev)) c = (c == 8) ? 0 : c + 1;
      return 4'(c);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock edge; m_pick keeps the LFSR value seen during the cycle that just ended.
   task automatic tick();
      @(posedge clk);
      m_pick = m_lfsr;
      if (reset)          m_lfsr = 16'hACE1;
      else if (load_seed) m_lfsr = (seed == '0) ? 16'h0001 : seed;
      else                m_lfsr = lfsr_step(m_lfsr);
      #1;
   endtask

   task automatic wait_valid(output int n, input int limit);
      n = 0;
      while (!light_valid && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] prev;
      logic [3:0] exp_pos;
      logic [3:0] wrong_pos;
      int rises, bad_range, bad_rep, bad_model;
      bit was_valid;

      do_reset();
      check("rst_lights", 32'(lights), 0);
      check("rst_valid", 32'(light_valid), 0);
      check("rst_pos", 32'(light_pos), 0);
      check("rst_flick", 32'(flick_count), 0);
      check("rst_done", 32'(done), 0);

      // Basic flick timing: gap 3, on 5, no hits
      seed = 16'h1234; load_seed = 1'b1; start = 1'b1;
      time_between = 28'd3; time_on = 28'd5; round_len = '0;
      tick();
      load_seed = 1'b0;
      wait_valid(n, 50);
      exp_pos = exp_pick(m_pick, 4'd0, 1'b1);
      check("gap_len", 32'(n), 5);
      check("pos_first", 32'(light_pos), 32'(exp_pos));
      check("lights_first", 32'(lights), 32'(9'd1 << exp_pos));
      prev = light_pos;
      n = 0;
      while (light_valid && n < 50) begin tick(); n++; end
      check("on_len", 32'(n), 6);
      check("miss_timeout", 32'(miss_count), 1);
      check("flick_one", 32'(flick_count), 1);
      check("lights_off", 32'(lights), 0);

      // Second flick: no-repeat pick, hit on 3rd lit cycle
      wait_valid(n, 50);
      check("gap_after_timeout", 32'(n), 6);
      exp_pos = exp_pick(m_pick, prev, 1'b0);
      check("pos_second", 32'(light_pos), 32'(exp_pos));
      tick(); tick();
      hits = 9'd1 << light_pos;
      tick();
      hits = '0;
      check("hit_clears", 32'(lights), 0);
      check("hit_count1", 32'(hit_count), 1);
      check("hit_no_miss", 32'(miss_count), 1);
      check("flick_two", 32'(flick_count), 2);
      wait_valid(n, 50);
      check("gap_after_hit", 32'(n), 6);

      // Wrong press while lit, then correct+wrong together
      wrong_pos = (light_pos == 4'd8) ? 4'd0 : light_pos + 4'd1;
      hits = 9'd1 << wrong_pos;
      tick();
      hits = '0;
      check("wrong_miss", 32'(miss_count), 2);
      check("wrong_keeps_light", 32'(light_valid), 1);
      hits = (9'd1 << light_pos) | (9'd1 << wrong_pos);
      tick();
      hits = '0;
      check("both_hit", 32'(hit_count), 2);
      check("both_miss", 32'(miss_count), 3);

      // Hit on the final lit cycle beats the timeout
      wait_valid(n, 50);
      repeat (5) tick();
      hits = 9'd1 << light_pos;
      tick();
      hits = '0;
      check("edge_hit", 32'(hit_count), 3);
      check("edge_no_timeout", 32'(miss_count), 3);
      tick();
      hits = 9'h001;
      tick();
      hits = '0;
      check("dark_press_miss", 32'(miss_count), 4);

      // Reset in the middle of WAIT_ON
      wait_valid(n, 50);
      tick();
      start = 1'b0;
      do_reset();
      check("midrst_lights", 32'(lights), 0);
      check("midrst_valid", 32'(light_valid), 0);
      check("midrst_hits", 32'(hit_count), 0);
      check("midrst_miss", 32'(miss_count), 0);
      check("midrst_done", 32'(done), 0);

      // Round of 4 with no hits
      time_between = 28'd1; time_on = 28'd2; round_len = 6'd4; start = 1'b1;
      n = 0;
      while (!done && n < 200) begin tick(); n++; end
      check("round_cycles", 32'(n), 29);
      check("round_done", 32'(done), 1);
      check("round_flicks", 32'(flick_count), 4);
      check("round_miss", 32'(miss_count), 4);
      tick();
      check("done_held", 32'(done), 1);
      check("flick_capped", 32'(flick_count), 4);
      start = 1'b0;
      tick();
      check("done_cleared", 32'(done), 0);
      check("counts_hold", 32'(flick_count), 4);
      start = 1'b1;
      tick();
      check("counts_cleared", 32'(flick_count), 0);

      // Pause during WAIT_ON
      start = 1'b0;
      do_reset();
      time_between = '0; time_on = 28'd20; round_len = '0; start = 1'b1;
      tick();
      wait_valid(n, 50);
      check("pause_gap", 32'(n), 2);
      check("pos_after_reset", 32'(light_pos), 32'(exp_pick(m_pick, 4'd0, 1'b1)));
      n = 0;
      repeat (3) begin tick(); n++; end
      start = 1'b0;
      repeat (10) begin tick(); n++; end
      check("pause_hold", 32'(light_valid), 1);
      start = 1'b1;
      while (light_valid && n < 100) begin tick(); n++; end
      check("pause_on_len", 32'(n), 31);

      // Seed 0, 200 fast flicks
      start = 1'b0;
      do_reset();
      seed = '0; load_seed = 1'b1; start = 1'b1; time_on = '0;
      tick();
      load_seed = 1'b0;
      rises = 0; bad_range = 0; bad_rep = 0; bad_model = 0;
      was_valid = 1'b0; prev = '0; n = 0;
      while (rises < 200 && n < 3000) begin
         tick();
         n++;
         if (light_valid && !was_valid) begin
            if (light_pos > 4'd8) bad_range++;
            if (rises != 0 && light_pos == prev) bad_rep++;
            if (light_pos != exp_pick(m_pick, prev, rises == 0)) bad_model++;
            prev = light_pos;
            rises++;
         end
         was_valid = light_valid;
      end
      check("seed0_rises", 32'(rises), 200);
      check("seed0_range", 32'(bad_range), 0);
      check("seed0_repeat", 32'(bad_rep), 0);
      check("seed0_model", 32'(bad_model), 0);
      check("flick_sat", 32'(flick_count), 63);
      check("miss_sat", 32'(miss_count), 63);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
